blinky_pattern_decoder: RTL
===========================

// Module: blinky_pattern_decoder
// PURPOSE
//  Receive side of the 8-LED blink pattern stream: samples an 8-bit pattern bus once per
//  step strobe, locks onto the 106-step frame, checks every step against the expected
//  pattern, and reports current phase, frame position, decoded final-sequence digits and
//  an error count. Sits on io_in of a second tile (or loopback) facing the blinky generator.
// PARAMETERS
//  ERR_W       8  width of saturating mismatch counter err_cnt
//  MISS_LIMIT  1  consecutive mismatches that drop lock (legal 1..7)
// PORTS
//  clk25        in   1      system clock, all logic on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  sample       in   1      step strobe; each clk25 cycle with sample=1 is one step
//  pat          in   8      pattern byte, valid when sample=1 (bit7 = MSB LED)
//  locked       out  1      frame lock acquired and held
//  phase        out  3      0 NONE,1 FILL,2 DRAIN,3 WALK_DN,4 WALK_UP,5 BLINK,6 NIBBLE,7 DIGITS
//  step         out  7      frame position 0..105 of last accepted sample (0 when unlocked)
//  digit_valid  out  1      1-cycle pulse: a one-hot digit step was decoded
//  digit        out  3      bit index from MSB of the one-hot byte (80->0 ... 01->7)
//  frame_done   out  1      1-cycle pulse when step 105 is accepted while locked
//  err_cnt      out  ERR_W  saturating count of mismatched locked steps
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=HUNT, history cleared. Reset dominates sample.
//  - All outputs registered; update on the clk25 edge where sample=1 (latency 1 cycle).
//    Cycles with sample=0 change nothing except clearing pulses.
//  - Expected byte E(s), s=frame step:
//    s=0:00 | 1..8: FF<<(8-s) | 9..17: FF<<(s-9) (s=17 gives 00) | 18..25: 80>>(s-18)
//    26..33: 01<<(s-26) | 34:00 | 35..55: odd 00, even FF | 56..72: odd F0, even 0F
//    73..105: odd 00, even = any one-hot byte (digit step)
//  - Phase map: 1..8 FILL, 9..17 DRAIN, 18..25 WALK_DN, 26..33 WALK_UP, 34..55 BLINK,
//    56..72 NIBBLE, 73..105 and 0 DIGITS; phase=0 whenever locked=0.
//  - FSM HUNT: keeps last two samples. Acquire only on sequence 00,80,C0 (unique to FILL;
//    00,80 alone is ambiguous with steps 17-18 and digit steps). On the C0 sample:
//    locked=1, step=2, phase=FILL. No error counting while hunting.
//  - FSM LOCK: each sample, s_next = (step==105)?0:step+1; compare pat to E(s_next).
//    Match: step<=s_next, miss counter cleared. Mismatch: err_cnt+1 (saturates at
//    2^ERR_W-1), miss counter+1, step still advances; if miss counter reaches MISS_LIMIT
//    -> locked=0, step=0, phase=0, back to HUNT with history = {prev,pat} of current byte.
//  - Digit step (even s in 74..104): one-hot pat -> digit_valid=1, digit=index;
//    non-one-hot (incl. 00) is a mismatch, no digit_valid. Digit values are not
//    order-checked (generator cycles 2,6,0,3,5).
//  - frame_done pulses on accepting s=105 even if that step mismatched without unlocking.
//  - Wrap 105->0 is seamless; lock persists across frames without re-acquire.
//  - pat with sample=0 is ignored entirely. Back-to-back sample cycles are legal.
// TESTING
//  1 Reset mid-frame (rst_n low while locked at step 40) -> all outputs 0 immediately
//    (async), HUNT after release; err_cnt=0.
//  2 Feed full clean frame from step 0 -> locked rises on 3rd sample (C0), step=2,
//    phase follows map, frame_done at step 105, err_cnt=0; second frame stays locked.
//  3 Feed ...,00(s17),80(s18),40 while hunting -> no lock; then 00,80,C0 -> lock.
//  4 Digit region bytes 00,20,00,02,00,80,00,10,00,04 -> digit_valid x5, digits 2,6,0,3,5.
//  5 MISS_LIMIT=1, corrupt step 40 (FF->FB) -> err_cnt=1, locked=0, phase=0 next cycle;
//    MISS_LIMIT=2, single corrupt -> stays locked, step continues to 41.
//  6 ERR_W=2, 5 isolated mismatches with MISS_LIMIT=7 -> err_cnt saturates at 3.

Source files
------------

// File: rtl/blinky_pattern_decoder.sv
// Receive side of the 8-LED blink pattern stream: locks onto the 106-step frame,
// checks each sampled step against the expected pattern and decodes final-sequence digits.
module blinky_pattern_decoder #(
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned MISS_LIMIT = 1
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             sample,
  input  logic [7:0]       pat,
  output logic             locked,
  output logic [2:0]       phase,
  output logic [6:0]       step,
  output logic             digit_valid,
  output logic [2:0]       digit,
  output logic             frame_done,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state, state_nx;
  logic [7:0]       hist1, hist0, hist1_nx, hist0_nx;
  logic [2:0]       miss, miss_nx;
  logic             locked_nx, dv_nx, fd_nx;
  logic [2:0]       phase_nx, digit_nx;
  logic [6:0]       step_nx, s_next;
  logic [ERR_W-1:0] err_nx;
  logic             match, dstep;
  logic [3:0]       miss_inc;

  function automatic logic [7:0] expected(input logic [6:0] s);
    int unsigned si;
    logic [7:0]  e;
    si = {25'd0, s};
    e  = '0;
    if (si == 0)        e = '0;
    else if (si <= 8)   e = 8'hFF << (8 - si);
    else if (si <= 17)  e = 8'hFF << (si - 9);
    else if (si <= 25)  e = 8'h80 >> (si - 18);
    else if (si <= 33)  e = 8'h01 << (si - 26);
    else if (si == 34)  e = '0;
    else if (si <= 55)  e = s[0] ? 8'h00 : 8'hFF;
    else if (si <= 72)  e = s[0] ? 8'hF0 : 8'h0F;
    else                e = '0;
    return e;
  endfunction

  function automatic logic [2:0] phase_of(input logic [6:0] s);
    int unsigned si;
    logic [2:0]  p;
    si = {25'd0, s};
    if (si == 0 || si >= 73) p = 3'd7;
    else if (si <= 8)        p = 3'd1;
    else if (si <= 17)       p = 3'd2;
    else if (si <= 25)       p = 3'd3;
    else if (si <= 33)       p = 3'd4;
    else if (si <= 55)       p = 3'd5;
    else                     p = 3'd6;
    return p;
  endfunction

  function automatic logic [2:0] onehot_index(input logic [7:0] b);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (b[7-i]) idx = 3'(i);
    return idx;
  endfunction

  assign s_next   = (step == 7'd105) ? '0 : step + 7'd1;
  assign dstep    = (s_next >= 7'd74) && (s_next <= 7'd104) && !s_next[0];
  assign miss_inc = {1'b0, miss} + 4'd1;

  always_comb begin
    match = 1'b0;
    if (dstep) match = (pat != '0) && ((pat & (pat - 8'd1)) == '0);
    else       match = (pat == expected(s_next));
  end

  always_comb begin
    state_nx  = state;
    hist1_nx  = hist1;
    hist0_nx  = hist0;
    miss_nx   = miss;
    locked_nx = locked;
    phase_nx  = phase;
    step_nx   = step;
    dv_nx     = 1'b0;
    digit_nx  = digit;
    fd_nx     = 1'b0;
    err_nx    = err_cnt;
    if (sample) begin
      // History shifts in every state so an unlock leaves {prev, pat} for re-acquire
      hist1_nx = hist0;
      hist0_nx = pat;
      unique case (state)
        HUNT: begin
          if (hist1 == 8'h00 && hist0 == 8'h80 && pat == 8'hC0) begin
            state_nx  = LOCK;
            locked_nx = 1'b1;
            step_nx   = 7'd2;
            phase_nx  = 3'd1;
            miss_nx   = '0;
          end
        end
        LOCK: begin
          if (match) begin
            miss_nx = '0;
          end else begin
            miss_nx = miss_inc[2:0];
            if (err_cnt != '1) err_nx = err_cnt + 1'b1;
          end
          if (!match && miss_inc >= 4'(MISS_LIMIT)) begin
            state_nx  = HUNT;
            locked_nx = 1'b0;
            step_nx   = '0;
            phase_nx  = '0;
            miss_nx   = '0;
          end else begin
            step_nx  = s_next;
            phase_nx = phase_of(s_next);
            fd_nx    = (s_next == 7'd105);
            if (match && dstep) begin
              dv_nx    = 1'b1;
              digit_nx = onehot_index(pat);
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      hist1       <= '0;
      hist0       <= '0;
      miss        <= '0;
      locked      <= 1'b0;
      phase       <= '0;
      step        <= '0;
      digit_valid <= 1'b0;
      digit       <= '0;
      frame_done  <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nx;
      hist1       <= hist1_nx;
      hist0       <= hist0_nx;
      miss        <= miss_nx;
      locked      <= locked_nx;
      phase       <= phase_nx;
      step        <= step_nx;
      digit_valid <= dv_nx;
      digit       <= digit_nx;
      frame_done  <= fd_nx;
      err_cnt     <= err_nx;
    end
  end

endmodule
